arbiter_n: RTL and testbench
============================

Name: arbiter_n

Overview:
- N-way fixed-priority arbiter. It grants the single highest-priority active request.
- The one-hot grant is combinational, zero latency. The same result is also available as registered outputs for timing-closed consumers.
- Used wherever one shared resource is selected among N requesters. Bit 0 of the request vector has highest priority.

Parameters:
- N, default 4: number of requesters. Legal range is N >= 1.
- IW, default max(1, $clog2(N)): width of the binary grant index. Derived; must not be overridden.

Ports:
- clk  input  1  rising-edge clock for the registered outputs.
- rst  input  1  synchronous, active-high reset; clears the registered outputs only.
- r  input  [0:N-1]  request vector. r[0] is the leftmost bit (the MSB when r is loaded from an integer) and has highest priority.
- g  output  [0:N-1]  combinational one-hot grant; all zeros when no request is active.
- any  output  1  combinational; 1 when any r bit is set.
- idx  output  IW  combinational binary index of the granted bit; 0 when any=0.
- g_q  output  [0:N-1]  g registered on clk.
- any_q  output  1  any registered on clk.
- idx_q  output  IW  idx registered on clk.

Behaviour:
- Combinational path, zero latency from r:
  - g[i] = 1 exactly when r[i] = 1 and r[j] = 0 for all j < i.
  - The lowest-numbered (leftmost) set bit wins; all other g bits are 0.
  - g has at most one bit set. g = 0 iff r = 0.
  - any equals the OR-reduction of r.
  - idx is the position i of the set g bit. idx = 0 when r = 0; use any to tell this apart from a grant to requester 0.
  - No X propagation on known inputs; the path must settle with no latches.
- Registered path:
  - At each rising clk with rst=0: g_q <= g, any_q <= any, idx_q <= idx. One-cycle latency.
  - At each rising clk with rst=1: g_q <= 0, any_q <= 0, idx_q <= 0. The combinational outputs keep following r during reset.
  - Reset asserted mid-stream clears the registered outputs on that edge. The first edge after rst deasserts captures the current r.
- No state beyond the output registers.
  - No fairness, rotation or grant locking.
  - A request held continuously keeps its grant until a higher-priority request appears.
  - Any change in r re-arbitrates immediately on g, and on g_q at the next edge.
- N=1: g = r, idx is always 0, IW = 1.
- The combinational result must be correct for every N without enumerating cases. Use a prefix-OR ("higher request seen") chain or tree so depth scales at most as O(N).

Decomposition:
- Shared package arbiter_pkg:
  - function clog2_min1(n), returning max(1, $clog2(n)), used for IW.
  - function onehot_to_idx for converting a one-hot vector to a binary index, reused by other arbiters.
- One sub-module, arb_prio_enc #(N): the purely combinational r to {g, any, idx} logic.
- arbiter_n instantiates arb_prio_enc and adds the output register stage.

Test Plan:
- Exhaustive, N=4: drive r = 0 .. 15 as an integer and wait for settling. Each value must give g equal to the first-set-bit one-hot, e.g. r=0110 -> g=0100, idx=1, any=1. Any mismatch prints r, g and expected, and the run reports FAILED; otherwise PASSED.
- Boundaries, N=4:
  - r=0000 -> g=0000, any=0, idx=0.
  - r=1111 -> g=1000, idx=0.
  - r=0001 -> g=0001, idx=3.
  - r=0101 -> g=0100, idx=1.
- Registered path: with rst=0, r=0011 before an edge -> g_q=0010, idx_q=2, any_q=1 after that edge. r then changes to 1000 -> g changes immediately; g_q changes one edge later.
- Reset mid-stream: r=0110 held and rst=1 for one edge -> g_q=0000, any_q=0, idx_q=0 while g=0100 stays. After rst deasserts, the next edge gives g_q=0100.
- Parameter sweep: N=1 exhaustive (r=1 -> g=1), and N=8 exhaustive over 256 values. The one-hot/zero property must hold on g every cycle (assertion).

Source files
------------

// File: rtl/arbiter_pkg.sv
// Shared arbiter helpers: index-width sizing and one-hot to
// binary conversion used by all arbiter flavours.
package arbiter_pkg;

  localparam int OH_MAX = 256;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Left-aligned one-hot in, position out; OR of set indices
  // is exact for one-hot and 0 for an all-zero vector.
  function automatic int unsigned onehot_to_idx(
    input logic [0:OH_MAX-1] oh
  );
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < OH_MAX; i++)
      if (oh[i]) res = res | i;
    return res;
  endfunction

endpackage

// File: rtl/arbiter_n_if.sv
// Request/grant bundle between requesters and arbiter_n,
// carrying both the combinational and the registered result.
interface arbiter_n_if
  import arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2_min1(N)
);

  logic [0:N-1]  r;
  logic [0:N-1]  g;
  logic          any;
  logic [IW-1:0] idx;
  logic [0:N-1]  g_q;
  logic          any_q;
  logic [IW-1:0] idx_q;

  modport master (
    output r,
    input  g, any, idx,
    input  g_q, any_q, idx_q
  );

  modport slave (
    input  r,
    output g, any, idx,
    output g_q, any_q, idx_q
  );

endinterface

// File: rtl/arb_prio_enc.sv
// Combinational fixed-priority encoder, bit 0 highest:
// prefix-OR chain gives the grant, then one-hot to index.
module arb_prio_enc
  import arbiter_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = clog2_min1(N)
) (
  input  logic [0:N-1]  r,
  output logic [0:N-1]  g,
  output logic          any,
  output logic [IW-1:0] idx
);

  logic [0:N-1]        seen;
  logic [0:OH_MAX-1]   pad;

  // seen[i]: some higher-priority bit j < i is requesting
  always_comb begin
    seen = '0;
    for (int i = 1; i < N; i++)
      seen[i] = seen[i-1] | r[i-1];
  end

  assign g   = r & ~seen;
  assign any = |r;

  always_comb begin
    pad        = '0;
    pad[0:N-1] = g;
  end

  assign idx = IW'(onehot_to_idx(pad));

endmodule

// File: rtl/arbiter_n.sv
// N-way fixed-priority arbiter with zero-latency grant and
// a registered copy of the same result.
module arbiter_n
  import arbiter_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = clog2_min1(N)
) (
  input logic        clk,
  input logic        rst,
  arbiter_n_if.slave bus
);

  logic [0:N-1]  g;
  logic          any;
  logic [IW-1:0] idx;

  arb_prio_enc #(.N(N)) u_enc (
    .r   (bus.r),
    .g   (g),
    .any (any),
    .idx (idx)
  );

  assign bus.g   = g;
  assign bus.any = any;
  assign bus.idx = idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.g_q   <= '0;
      bus.any_q <= 1'b0;
      bus.idx_q <= '0;
    end else begin
      bus.g_q   <= g;
      bus.any_q <= any;
      bus.idx_q <= idx;
    end
  end

endmodule

// File: tb/tb_arbiter_n.sv
// Self-checking bench for arbiter_n at N=1, 4 and 8:
// vector table, exhaustive sweeps and registered sequences.
module tb_arbiter_n;

  typedef struct {
    logic [3:0] g4;
    logic       a4;
    logic [1:0] i4;
    logic [7:0] g8;
    logic       a8;
    logic [2:0] i8;
    logic       g1;
    logic       a1;
  } exp_t;

  typedef struct {
    logic [3:0] r;
    logic [3:0] g;
    logic       any;
    logic [1:0] idx;
  } vec_t;

  logic clk;
  logic rst;
  int   ncmp;
  int   nfail;
  exp_t sb[$];
  exp_t last;
  bit   have_last;
  vec_t tbl[4];

  arbiter_n_if #(.N(4)) bus4 ();
  arbiter_n_if #(.N(8)) bus8 ();
  arbiter_n_if #(.N(1)) bus1 ();

  arbiter_n #(.N(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  arbiter_n #(.N(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  arbiter_n #(.N(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    assert ($onehot0(bus4.g));
    assert ($onehot0(bus8.g));
    assert ((bus4.g == 0) == (bus4.r == 0));
    assert ((bus8.g == 0) == (bus8.r == 0));
  end

  function automatic exp_t model(
    input logic [3:0] v4,
    input logic [7:0] v8,
    input logic       v1
  );
    exp_t e;
    int   k;
    e = '{default: '0};
    k = -1;
    for (int i = 0; i < 4; i++)
      if (k < 0 && v4[3-i]) k = i;
    if (k >= 0) begin
      e.g4 = 4'b1000 >> k;
      e.a4 = 1'b1;
      e.i4 = 2'(k);
    end
    k = -1;
    for (int i = 0; i < 8; i++)
      if (k < 0 && v8[7-i]) k = i;
    if (k >= 0) begin
      e.g8 = 8'h80 >> k;
      e.a8 = 1'b1;
      e.i8 = 3'(k);
    end
    e.g1 = v1;
    e.a1 = v1;
    return e;
  endfunction

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_regs(input string sfx, input exp_t e);
    chk({"reg4", sfx},
        32'({bus4.g_q, bus4.any_q, bus4.idx_q}),
        32'({e.g4, e.a4, e.i4}));
    chk({"reg8", sfx},
        32'({bus8.g_q, bus8.any_q, bus8.idx_q}),
        32'({e.g8, e.a8, e.i8}));
    chk({"reg1", sfx},
        32'({bus1.g_q, bus1.any_q, bus1.idx_q}),
        32'({e.g1, e.a1, 1'b0}));
  endtask

  task automatic step(
    input logic [3:0] v4,
    input logic [7:0] v8,
    input logic       v1,
    input logic       rs
  );
    exp_t e;
    exp_t q;
    exp_t z;
    z = '{default: '0};
    @(negedge clk);
    bus4.r = v4;
    bus8.r = v8;
    bus1.r = v1;
    rst    = rs;
    #1;
    e = model(v4, v8, v1);
    chk("comb4",
        32'({bus4.g, bus4.any, bus4.idx}),
        32'({e.g4, e.a4, e.i4}));
    chk("comb8",
        32'({bus8.g, bus8.any, bus8.idx}),
        32'({e.g8, e.a8, e.i8}));
    chk("comb1",
        32'({bus1.g, bus1.any, bus1.idx}),
        32'({e.g1, e.a1, 1'b0}));
    if (have_last) chk_regs("_hold", last);
    sb.push_back(rs ? z : e);
    @(posedge clk);
    #1;
    q = sb.pop_front();
    chk_regs("", q);
    last      = q;
    have_last = 1'b1;
  endtask

  initial begin
    ncmp      = 0;
    nfail     = 0;
    have_last = 1'b0;
    rst       = 1'b1;
    bus4.r    = '0;
    bus8.r    = '0;
    bus1.r    = '0;

    tbl[0] = '{4'b0000, 4'b0000, 1'b0, 2'd0};
    tbl[1] = '{4'b1111, 4'b1000, 1'b1, 2'd0};
    tbl[2] = '{4'b0001, 4'b0001, 1'b1, 2'd3};
    tbl[3] = '{4'b0101, 4'b0100, 1'b1, 2'd1};

    // reset state
    step(4'b0000, 8'h00, 1'b0, 1'b1);

    foreach (tbl[i]) begin
      step(tbl[i].r, {tbl[i].r, 4'b0000}, tbl[i].r[0], 1'b0);
      chk("tbl_g4", 32'(bus4.g), 32'(tbl[i].g));
      chk("tbl_any4", 32'(bus4.any), 32'(tbl[i].any));
      chk("tbl_idx4", 32'(bus4.idx), 32'(tbl[i].idx));
      chk("tbl_gq4", 32'(bus4.g_q), 32'(tbl[i].g));
    end

    // registered path: r=0011 then 1000
    step(4'b0011, 8'h03, 1'b1, 1'b0);
    chk("seq_gq", 32'(bus4.g_q), 32'h2);
    chk("seq_idxq", 32'(bus4.idx_q), 32'd2);
    @(negedge clk);
    bus4.r = 4'b1000;
    #1;
    chk("seq_g_now", 32'(bus4.g), 32'h8);
    chk("seq_gq_old", 32'(bus4.g_q), 32'h2);
    @(posedge clk);
    #1;
    chk("seq_gq_new", 32'(bus4.g_q), 32'h8);
    chk("seq_idxq_new", 32'(bus4.idx_q), 32'd0);
    have_last = 1'b0;

    // reset mid-stream
    step(4'b0110, 8'h60, 1'b1, 1'b0);
    step(4'b0110, 8'h60, 1'b1, 1'b1);
    chk("rst_g_live", 32'(bus4.g), 32'h4);
    chk("rst_gq", 32'(bus4.g_q), 32'h0);
    step(4'b0110, 8'h60, 1'b1, 1'b0);
    chk("rst_after_gq", 32'(bus4.g_q), 32'h4);
    chk("rst_after_idxq", 32'(bus4.idx_q), 32'd1);

    // exhaustive: N=8 over 256, N=4 and N=1 along
    for (int v = 0; v < 256; v++) begin
      logic [7:0] vv;
      vv = 8'(v);
      step(vv[3:0], vv, vv[0], 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
